idli_serial_ex: RTL and testbench
=================================

# idli_serial_ex

Parametrised slice-serial execution unit: accepts LHS/RHS operands one `SLICE_W`-bit slice per cycle, LSB slice first. It computes an ALU operation with inter-slice carry, or a full-word shift by an arbitrary amount, plus a comparison flag. The result streams back out LSB-first over a valid/ready handshake. It generalises the fixed 4x4b datapath to arbitrary slice width and slice count and adds multi-bit shifts and output backpressure. It sits between operand fetch and writeback in the core pipeline.

## Interface
- `SLICE_W`, 4: bits per slice; must be >= 1.
- `NUM_SLICES`, 4: slices per word; must be >= 1.
- `DATA_W` (localparam) = `SLICE_W*NUM_SLICES`; must be >= 2.
- `SHAMT_W` (localparam) = `$clog2(DATA_W)`.
- `i_clk`  in  1  clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_in_vld`  in  1  input slice valid.
- `o_in_rdy`  out  1  input slice ready.
- `i_lhs`, `i_rhs`  in  `SLICE_W`  operand slices.
- `i_pipe`  in  `pipe_t`  selects ALU or shift result.
- `i_alu_op`  in  `alu_op_t`  ALU operation.
- `i_rhs_inv`  in  1  invert RHS; also ADD carry-in.
- `i_cmp_op`  in  `cmp_op_t`  comparison.
- `i_shift_op`  in  `shift_op_t`  shift operation.
- `i_shamt`  in  `SHAMT_W`  shift amount.
- `o_out_vld`  out  1  output slice valid.
- `i_out_rdy`  in  1  output slice ready.
- `o_out`  out  `SLICE_W`  result slice.
- `o_out_last`  out  1  marks final output slice.
- `o_cmp_vld`  out  1  one-cycle pulse: `o_cmp` valid.
- `o_cmp`  out  1  comparison result.
- `o_busy`  out  1  word in flight (partial fill or drain).

## Operation
- Two states, FILL and DRAIN; a slice counter of `$clog2(NUM_SLICES)` bits (minimum 1) is shared by both.
- **FILL**
  - `o_in_rdy`=1. A slice is accepted on `i_in_vld & o_in_rdy`.
  - Control inputs (`i_pipe`, ops, `i_rhs_inv`, `i_shamt`) are sampled only with slice 0 and held for the word. Later changes are ignored.
- **ALU**
  - Effective RHS = `i_rhs ^ {SLICE_W{i_rhs_inv}}`.
  - ADD: carry-in of slice 0 is `i_rhs_inv`; each later slice takes the previous slice's carry-out. Final carry-out is discarded.
  - AND/OR/XOR are bitwise on the effective RHS.
  - Each result slice is written to result-buffer position = counter.
- **Compare**
  - Always evaluated on LHS - RHS (RHS inverted, carry-in 1), independent of `i_alu_op` and `i_rhs_inv`.
  - Tracked during fill: zero (all difference bits 0), final carry C, difference MSB N, signed overflow V.
  - EQ=Z, NE=!Z, LTU=!C, GEU=C, LT=N^V, GE=!(N^V), ANY=1.
- **Shift**
  - Operand is LHS only; RHS is ignored. Shift amount n = `i_shamt`, in range 0..DATA_W-1.
  - LHS slices are buffered. At the end of fill the full word is shifted: ROR/ROL rotate by n; SRL fills with 0; SRA fills with the word MSB. n=0 gives identity.
- **FILL to DRAIN**
  - Triggered by accepting slice `NUM_SLICES-1`.
  - Next cycle: counter=0, `o_cmp_vld` pulses 1 for exactly one cycle, `o_out_vld`=1.
- **DRAIN**
  - `o_in_rdy`=0; `i_in_vld` is ignored.
  - `o_out` = buffer slice[counter]; `o_out_last`=1 when counter = `NUM_SLICES-1`.
  - The counter advances on `o_out_vld & i_out_rdy`.
  - Handshake of the last slice: next cycle state=FILL, counter=0, `o_out_vld`=0.
- `o_busy`=1 in DRAIN, and in FILL when counter≠0.
- `NUM_SLICES`=1: fill takes one accept and drain one handshake.

## Timing
- Reset values:
  - `o_in_rdy`=1; `o_out_vld`, `o_out_last`, `o_cmp_vld`, `o_cmp`, `o_busy`=0; `o_out`=0.
  - State=FILL, counter=0, buffers cleared.
- Latency: first output slice is valid the cycle after the last input slice is accepted.
- Throughput, zero backpressure: one word per 2×`NUM_SLICES` cycles.
- `o_cmp` holds its value until the next `o_cmp_vld` pulse.
- While `i_out_rdy`=0: `o_out`, `o_out_last` and `o_out_vld` are held stable, and no slice is dropped or repeated.
- Input gaps (`i_in_vld`=0 mid-fill): state and counter are held; carry and compare flags are preserved.
- Reset asserted mid-fill or mid-drain:
  - All outputs go to reset values immediately (async); any partial word is discarded.
  - The first accept after deassert is treated as slice 0.
- All ALU and shift arithmetic is modulo 2^`DATA_W`.

## Test plan
- ADD, default params: LHS 0x1234 (slices 4,3,2,1), RHS 0x0FFF -> out slices 3,3,2,2 (0x2233); `o_out_last` on 4th slice; first out 1 cycle after last accept.
- ADD with `i_rhs_inv`=1, cmp LT: LHS 0x0001, RHS 0x0002 -> result 0xFFFF, `o_cmp`=1. Repeat with GE -> 0, LTU -> 1, EQ on 0x5A5A/0x5A5A -> 1.
- Shifts:
  - SRA n=4 on 0x8F00 -> 0xF8F0.
  - ROL n=1 on 0x8001 -> 0x0003.
  - ROR n=15 on 0x0001 -> 0x0002.
  - SRL n=0 on 0xBEEF -> 0xBEEF.
- Backpressure: `i_out_rdy`=0 for 3 cycles at drain slice 1 -> `o_out` stable, `o_in_rdy`=0, all 4 slices delivered in order; `i_in_vld` pulses during drain are ignored.
- Reset after 2 fill slices -> outputs at reset values, `o_busy`=0. Next word XOR 0xF0F0^0x0FF0 -> 0xFF00.
- `SLICE_W`=2, `NUM_SLICES`=8: ADD 0xFFFF+0x0001 -> 0x0000, EQ vs 0xFFFF -> 0. `NUM_SLICES`=1, `SLICE_W`=8: SRA n=7 on 0x80 -> 0xFF.

Source files
------------

// File: rtl/idli_serial_ex.sv
// Slice-serial execution unit: ALU with inter-slice carry, full-word shifter and
// compare flag. Operands arrive LSB slice first; results drain LSB first with backpressure.
package idli_serial_ex_pkg;
  typedef enum logic {PIPE_ALU = 1'b0, PIPE_SHIFT = 1'b1} pipe_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_OR, ALU_XOR} alu_op_t;
  typedef enum logic [2:0] {CMP_EQ, CMP_NE, CMP_LTU, CMP_GEU, CMP_LT, CMP_GE, CMP_ANY} cmp_op_t;
  typedef enum logic [1:0] {SHIFT_SRL, SHIFT_SRA, SHIFT_ROR, SHIFT_ROL} shift_op_t;
endpackage

module idli_serial_ex
  import idli_serial_ex_pkg::*;
#(
  parameter int SLICE_W = 4,
  parameter int NUM_SLICES = 4,
  localparam int DATA_W = SLICE_W * NUM_SLICES,
  localparam int SHAMT_W = $clog2(DATA_W)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_in_vld,
  output logic               o_in_rdy,
  input  logic [SLICE_W-1:0] i_lhs,
  input  logic [SLICE_W-1:0] i_rhs,
  input  pipe_t              i_pipe,
  input  alu_op_t            i_alu_op,
  input  logic               i_rhs_inv,
  input  cmp_op_t            i_cmp_op,
  input  shift_op_t          i_shift_op,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic               o_out_vld,
  input  logic               i_out_rdy,
  output logic [SLICE_W-1:0] o_out,
  output logic               o_out_last,
  output logic               o_cmp_vld,
  output logic               o_cmp,
  output logic               o_busy
);
  localparam int CNT_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SLICES - 1);

  typedef enum logic {ST_FILL, ST_DRAIN} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  pipe_t              pipe_reg;
  alu_op_t            alu_op_reg;
  logic               rhs_inv_reg;
  cmp_op_t            cmp_op_reg;
  shift_op_t          shift_op_reg;
  logic [SHAMT_W-1:0] shamt_reg;
  logic               alu_c_reg, cmp_c_reg, cmp_z_reg;
  logic               cmp_reg, cmp_vld_reg;
  logic [DATA_W-1:0]  buf_reg;

  logic               accept, first, is_last;
  pipe_t              pipe_e;
  alu_op_t            alu_op_e;
  logic               rhs_inv_e;
  cmp_op_t            cmp_op_e;
  shift_op_t          shift_op_e;
  logic [SHAMT_W-1:0] shamt_e;
  logic [SLICE_W-1:0] rhs_eff, alu_slice, slice_val, diff;
  logic [SLICE_W:0]   add_full, sub_full;
  logic               alu_cin, cmp_cin, z_next, flag_n, flag_v, cmp_eval;
  logic [DATA_W-1:0]  word_full, shift_res;
  logic [SHAMT_W:0]   rot_amt;

  assign accept  = (state_reg == ST_FILL) && i_in_vld;
  assign first   = (cnt_reg == '0);
  assign is_last = (cnt_reg == CNT_LAST);

  // Controls come straight from the inputs on slice 0, from the latched copy afterwards.
  assign pipe_e     = first ? i_pipe     : pipe_reg;
  assign alu_op_e   = first ? i_alu_op   : alu_op_reg;
  assign rhs_inv_e  = first ? i_rhs_inv  : rhs_inv_reg;
  assign cmp_op_e   = first ? i_cmp_op   : cmp_op_reg;
  assign shift_op_e = first ? i_shift_op : shift_op_reg;
  assign shamt_e    = first ? i_shamt    : shamt_reg;

  assign rhs_eff  = i_rhs ^ {SLICE_W{rhs_inv_e}};
  assign alu_cin  = first ? rhs_inv_e : alu_c_reg;
  assign add_full = {1'b0, i_lhs} + {1'b0, rhs_eff} + {{SLICE_W{1'b0}}, alu_cin};

  always_comb begin
    alu_slice = add_full[SLICE_W-1:0];
    case (alu_op_e)
      ALU_AND: alu_slice = i_lhs & rhs_eff;
      ALU_OR:  alu_slice = i_lhs | rhs_eff;
      ALU_XOR: alu_slice = i_lhs ^ rhs_eff;
      default: alu_slice = add_full[SLICE_W-1:0];
    endcase
  end

  assign slice_val = (pipe_e == PIPE_SHIFT) ? i_lhs : alu_slice;

  // Compare always runs LHS - RHS, independent of the ALU operation.
  assign cmp_cin  = first ? 1'b1 : cmp_c_reg;
  assign sub_full = {1'b0, i_lhs} + {1'b0, ~i_rhs} + {{SLICE_W{1'b0}}, cmp_cin};
  assign diff     = sub_full[SLICE_W-1:0];
  assign z_next   = (first || cmp_z_reg) && (diff == '0);
  assign flag_n   = diff[SLICE_W-1];
  assign flag_v   = (i_lhs[SLICE_W-1] ^ i_rhs[SLICE_W-1]) & (i_lhs[SLICE_W-1] ^ diff[SLICE_W-1]);

  always_comb begin
    cmp_eval = 1'b1;
    case (cmp_op_e)
      CMP_EQ:  cmp_eval = z_next;
      CMP_NE:  cmp_eval = !z_next;
      CMP_LTU: cmp_eval = !sub_full[SLICE_W];
      CMP_GEU: cmp_eval = sub_full[SLICE_W];
      CMP_LT:  cmp_eval = flag_n ^ flag_v;
      CMP_GE:  cmp_eval = !(flag_n ^ flag_v);
      default: cmp_eval = 1'b1;
    endcase
  end

  // Buffered word with the slice being accepted this cycle merged in.
  for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_word
    assign word_full[gi*SLICE_W +: SLICE_W] =
      (cnt_reg == CNT_W'(gi)) ? slice_val : buf_reg[gi*SLICE_W +: SLICE_W];
  end

  // Rotates built from two opposite shifts; n=0 makes the complementary shift DATA_W, i.e. zero.
  assign rot_amt = (SHAMT_W + 1)'(DATA_W) - {1'b0, shamt_e};

  always_comb begin
    shift_res = word_full >> shamt_e;
    case (shift_op_e)
      SHIFT_SRA: shift_res = $unsigned($signed(word_full) >>> shamt_e);
      SHIFT_ROR: shift_res = (word_full >> shamt_e) | (word_full << rot_amt);
      SHIFT_ROL: shift_res = (word_full << shamt_e) | (word_full >> rot_amt);
      default:   shift_res = word_full >> shamt_e;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= ST_FILL;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_FILL: if (i_in_vld) begin
        if (is_last) begin
          state_next = ST_DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: if (i_out_rdy) begin
        if (is_last) begin
          state_next = ST_FILL;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    o_in_rdy   = (state_reg == ST_FILL);
    o_out_vld  = (state_reg == ST_DRAIN);
    o_out_last = (state_reg == ST_DRAIN) && is_last;
    o_busy     = (state_reg == ST_DRAIN) || !first;
    o_out      = (state_reg == ST_DRAIN) ? buf_reg[cnt_reg*SLICE_W +: SLICE_W] : '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pipe_reg     <= PIPE_ALU;
      alu_op_reg   <= ALU_ADD;
      rhs_inv_reg  <= 1'b0;
      cmp_op_reg   <= CMP_EQ;
      shift_op_reg <= SHIFT_SRL;
      shamt_reg    <= '0;
      alu_c_reg    <= 1'b0;
      cmp_c_reg    <= 1'b0;
      cmp_z_reg    <= 1'b0;
      cmp_reg      <= 1'b0;
      cmp_vld_reg  <= 1'b0;
      buf_reg      <= '0;
    end else begin
      cmp_vld_reg <= accept && is_last;
      if (accept) begin
        if (first) begin
          pipe_reg     <= i_pipe;
          alu_op_reg   <= i_alu_op;
          rhs_inv_reg  <= i_rhs_inv;
          cmp_op_reg   <= i_cmp_op;
          shift_op_reg <= i_shift_op;
          shamt_reg    <= i_shamt;
        end
        alu_c_reg <= add_full[SLICE_W];
        cmp_c_reg <= sub_full[SLICE_W];
        cmp_z_reg <= z_next;
        buf_reg   <= (is_last && pipe_e == PIPE_SHIFT) ? shift_res : word_full;
        if (is_last) cmp_reg <= cmp_eval;
      end
    end
  end

  assign o_cmp_vld = cmp_vld_reg;
  assign o_cmp     = cmp_reg;
endmodule

// File: tb/tb_idli_serial_ex.sv
// Directed bench for idli_serial_ex: default 4x4b instance plus 2x8 and 8x1 variants.
module tb_idli_serial_ex;
  import idli_serial_ex_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // default instance (4-bit slices x 4)
  logic a_vld = 0, a_irdy, a_ordy = 1, a_ovld, a_last, a_cvld, a_cmp, a_busy, a_inv = 0;
  logic [3:0] a_lhs = 0, a_rhs = 0, a_out, a_shamt = 0;
  pipe_t a_pipe = PIPE_ALU; alu_op_t a_alu = ALU_ADD; cmp_op_t a_cop = CMP_ANY; shift_op_t a_sh = SHIFT_SRL;

  // 2-bit slices x 8
  logic b_vld = 0, b_irdy, b_ordy = 1, b_ovld, b_last, b_cvld, b_cmp, b_busy, b_inv = 0;
  logic [1:0] b_lhs = 0, b_rhs = 0, b_out;
  logic [3:0] b_shamt = 0;
  pipe_t b_pipe = PIPE_ALU; alu_op_t b_alu = ALU_ADD; cmp_op_t b_cop = CMP_ANY; shift_op_t b_sh = SHIFT_SRL;

  // 8-bit slice x 1
  logic c_vld = 0, c_irdy, c_ordy = 1, c_ovld, c_last, c_cvld, c_cmp, c_busy, c_inv = 0;
  logic [7:0] c_lhs = 0, c_rhs = 0, c_out;
  logic [2:0] c_shamt = 0;
  pipe_t c_pipe = PIPE_ALU; alu_op_t c_alu = ALU_ADD; cmp_op_t c_cop = CMP_ANY; shift_op_t c_sh = SHIFT_SRL;

  idli_serial_ex #(.SLICE_W(4), .NUM_SLICES(4)) u_a (
    .i_clk(clk), .i_rst(rst), .i_in_vld(a_vld), .o_in_rdy(a_irdy), .i_lhs(a_lhs), .i_rhs(a_rhs),
    .i_pipe(a_pipe), .i_alu_op(a_alu), .i_rhs_inv(a_inv), .i_cmp_op(a_cop), .i_shift_op(a_sh),
    .i_shamt(a_shamt), .o_out_vld(a_ovld), .i_out_rdy(a_ordy), .o_out(a_out), .o_out_last(a_last),
    .o_cmp_vld(a_cvld), .o_cmp(a_cmp), .o_busy(a_busy));

  idli_serial_ex #(.SLICE_W(2), .NUM_SLICES(8)) u_b (
    .i_clk(clk), .i_rst(rst), .i_in_vld(b_vld), .o_in_rdy(b_irdy), .i_lhs(b_lhs), .i_rhs(b_rhs),
    .i_pipe(b_pipe), .i_alu_op(b_alu), .i_rhs_inv(b_inv), .i_cmp_op(b_cop), .i_shift_op(b_sh),
    .i_shamt(b_shamt), .o_out_vld(b_ovld), .i_out_rdy(b_ordy), .o_out(b_out), .o_out_last(b_last),
    .o_cmp_vld(b_cvld), .o_cmp(b_cmp), .o_busy(b_busy));

  idli_serial_ex #(.SLICE_W(8), .NUM_SLICES(1)) u_c (
    .i_clk(clk), .i_rst(rst), .i_in_vld(c_vld), .o_in_rdy(c_irdy), .i_lhs(c_lhs), .i_rhs(c_rhs),
    .i_pipe(c_pipe), .i_alu_op(c_alu), .i_rhs_inv(c_inv), .i_cmp_op(c_cop), .i_shift_op(c_sh),
    .i_shamt(c_shamt), .o_out_vld(c_ovld), .i_out_rdy(c_ordy), .o_out(c_out), .o_out_last(c_last),
    .o_cmp_vld(c_cvld), .o_cmp(c_cmp), .o_busy(c_busy));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One 16-bit word through u_a. Controls are scrambled after slice 0 to prove they are latched.
  task automatic word_a(input string tag, input pipe_t pipe, input alu_op_t alu, input logic inv,
                        input cmp_op_t cop, input shift_op_t sh, input logic [3:0] n,
                        input logic [15:0] lhs, input logic [15:0] rhs, input bit gap, input bit bp,
                        input logic [15:0] exp_res, input logic exp_cmp);
    logic [15:0] res;
    logic [3:0]  lastp;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      if (gap && s == 2) begin
        a_vld = 1'b0;
        @(negedge clk);
      end
      a_vld = 1'b1;
      a_lhs = lhs[s*4 +: 4];
      a_rhs = rhs[s*4 +: 4];
      if (s == 0) begin
        a_pipe = pipe; a_alu = alu; a_inv = inv; a_cop = cop; a_sh = sh; a_shamt = n;
      end else begin
        a_pipe = pipe_t'(~pipe); a_alu = alu_op_t'(~alu); a_inv = ~inv;
        a_cop = cmp_op_t'(cop ^ 3'd1); a_sh = shift_op_t'(~sh); a_shamt = ~n;
      end
    end
    @(negedge clk);
    a_vld = 1'b0;
    check({tag, ".latency_vld"}, 32'(a_ovld), 32'd1);
    check({tag, ".cmp_vld"}, 32'(a_cvld), 32'd1);
    check({tag, ".cmp"}, 32'(a_cmp), 32'(exp_cmp));
    for (int s = 0; s < 4; s++) begin
      if (s > 0) @(negedge clk);
      res[s*4 +: 4] = a_out;
      lastp[s] = a_last;
      if (bp && s == 1) begin
        a_ordy = 1'b0;
        a_vld = 1'b1;
        a_lhs = 4'hA;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check({tag, ".bp_hold"}, {a_ovld, a_last, a_irdy, a_out}, {1'b1, 1'b0, 1'b0, res[7:4]});
        end
        a_ordy = 1'b1;
        a_vld = 1'b0;
      end
    end
    @(negedge clk);
    check({tag, ".result"}, 32'(res), 32'(exp_res));
    check({tag, ".last_flags"}, 32'(lastp), 32'h8);
    check({tag, ".after_drain"}, {a_ovld, a_cvld, a_irdy, a_busy, a_cmp}, {4'b0010, exp_cmp});
    $display("word %s: res=%h cmp=%b last=%b", tag, res, a_cmp, lastp);
  endtask

  task automatic word_b(input string tag, input alu_op_t alu, input cmp_op_t cop,
                        input logic [15:0] lhs, input logic [15:0] rhs,
                        input logic [15:0] exp_res, input logic exp_cmp);
    logic [15:0] res;
    logic [7:0]  lastp;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      b_vld = 1'b1;
      b_lhs = lhs[s*2 +: 2];
      b_rhs = rhs[s*2 +: 2];
      b_alu = alu; b_cop = cop; b_pipe = PIPE_ALU; b_inv = 1'b0;
    end
    @(negedge clk);
    b_vld = 1'b0;
    check({tag, ".latency_vld"}, {b_ovld, b_cvld}, 2'b11);
    check({tag, ".cmp"}, 32'(b_cmp), 32'(exp_cmp));
    for (int s = 0; s < 8; s++) begin
      if (s > 0) @(negedge clk);
      res[s*2 +: 2] = b_out;
      lastp[s] = b_last;
    end
    @(negedge clk);
    check({tag, ".result"}, 32'(res), 32'(exp_res));
    check({tag, ".last_flags"}, 32'(lastp), 32'h80);
    check({tag, ".after_drain"}, {b_ovld, b_irdy, b_busy}, 3'b010);
    $display("word %s: res=%h cmp=%b last=%b", tag, res, b_cmp, lastp);
  endtask

  task automatic word_c(input string tag, input pipe_t pipe, input alu_op_t alu, input cmp_op_t cop,
                        input shift_op_t sh, input logic [2:0] n, input logic [7:0] lhs,
                        input logic [7:0] rhs, input logic [7:0] exp_res, input logic exp_cmp);
    @(negedge clk);
    c_vld = 1'b1; c_lhs = lhs; c_rhs = rhs;
    c_pipe = pipe; c_alu = alu; c_cop = cop; c_sh = sh; c_shamt = n; c_inv = 1'b0;
    @(negedge clk);
    c_vld = 1'b0;
    check({tag, ".latency_vld"}, {c_ovld, c_cvld, c_last, c_irdy, c_busy}, 5'b11101);
    check({tag, ".cmp"}, 32'(c_cmp), 32'(exp_cmp));
    check({tag, ".result"}, 32'(c_out), 32'(exp_res));
    $display("word %s: res=%h cmp=%b", tag, c_out, c_cmp);
    @(negedge clk);
    check({tag, ".after_drain"}, {c_ovld, c_cvld, c_irdy, c_busy}, 4'b0010);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    check("reset_a", {a_irdy, a_ovld, a_last, a_cvld, a_cmp, a_busy, a_out}, {6'b100000, 4'h0});
    check("reset_b", {b_irdy, b_ovld, b_cvld, b_cmp, b_busy, b_out}, {5'b10000, 2'b00});
    @(negedge clk);
    rst = 1'b0;

    word_a("add",       PIPE_ALU, ALU_ADD, 1'b0, CMP_ANY, SHIFT_SRL, 4'd0, 16'h1234, 16'h0FFF, 0, 0, 16'h2233, 1'b1);
    word_a("sub_lt",    PIPE_ALU, ALU_ADD, 1'b1, CMP_LT,  SHIFT_SRL, 4'd0, 16'h0001, 16'h0002, 1, 0, 16'hFFFF, 1'b1);
    word_a("sub_ge",    PIPE_ALU, ALU_ADD, 1'b1, CMP_GE,  SHIFT_SRL, 4'd0, 16'h0001, 16'h0002, 0, 0, 16'hFFFF, 1'b0);
    word_a("sub_ltu",   PIPE_ALU, ALU_ADD, 1'b1, CMP_LTU, SHIFT_SRL, 4'd0, 16'h0001, 16'h0002, 0, 0, 16'hFFFF, 1'b1);
    word_a("xor_eq",    PIPE_ALU, ALU_XOR, 1'b0, CMP_EQ,  SHIFT_SRL, 4'd0, 16'h5A5A, 16'h5A5A, 0, 0, 16'h0000, 1'b1);
    word_a("and_ne",    PIPE_ALU, ALU_AND, 1'b0, CMP_NE,  SHIFT_SRL, 4'd0, 16'hF0F0, 16'h3C3C, 0, 0, 16'h3030, 1'b1);
    word_a("or_inv_geu",PIPE_ALU, ALU_OR,  1'b1, CMP_GEU, SHIFT_SRL, 4'd0, 16'h1200, 16'h00FF, 0, 0, 16'hFF00, 1'b1);
    word_a("sra4",      PIPE_SHIFT, ALU_ADD, 1'b0, CMP_ANY, SHIFT_SRA, 4'd4,  16'h8F00, 16'h0000, 0, 0, 16'hF8F0, 1'b1);
    word_a("rol1",      PIPE_SHIFT, ALU_ADD, 1'b0, CMP_ANY, SHIFT_ROL, 4'd1,  16'h8001, 16'h0000, 0, 0, 16'h0003, 1'b1);
    word_a("ror15",     PIPE_SHIFT, ALU_ADD, 1'b0, CMP_ANY, SHIFT_ROR, 4'd15, 16'h0001, 16'h0000, 0, 0, 16'h0002, 1'b1);
    word_a("srl0",      PIPE_SHIFT, ALU_ADD, 1'b0, CMP_ANY, SHIFT_SRL, 4'd0,  16'hBEEF, 16'h1234, 0, 0, 16'hBEEF, 1'b1);
    word_a("add_bp",    PIPE_ALU, ALU_ADD, 1'b0, CMP_ANY, SHIFT_SRL, 4'd0, 16'h1234, 16'h0FFF, 0, 1, 16'h2233, 1'b1);

    // reset in the middle of a fill discards the partial word
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      a_vld = 1'b1; a_lhs = 4'h7; a_rhs = 4'h9; a_pipe = PIPE_ALU; a_alu = ALU_ADD; a_cop = CMP_ANY;
    end
    @(negedge clk);
    a_vld = 1'b0;
    check("midfill_busy", 32'(a_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midfill_reset", {a_irdy, a_ovld, a_last, a_cvld, a_cmp, a_busy, a_out}, {6'b100000, 4'h0});
    @(negedge clk);
    rst = 1'b0;
    word_a("xor_after_rst", PIPE_ALU, ALU_XOR, 1'b0, CMP_NE, SHIFT_SRL, 4'd0, 16'hF0F0, 16'h0FF0, 0, 0, 16'hFF00, 1'b1);

    word_b("b_add_wrap", ALU_ADD, CMP_EQ, 16'hFFFF, 16'h0001, 16'h0000, 1'b0);
    word_b("b_add_eq",   ALU_ADD, CMP_EQ, 16'h1234, 16'h1234, 16'h2468, 1'b1);

    word_c("c_sra7",   PIPE_SHIFT, ALU_ADD, CMP_ANY, SHIFT_SRA, 3'd7, 8'h80, 8'h00, 8'hFF, 1'b1);
    word_c("c_add_lt", PIPE_ALU,   ALU_ADD, CMP_LT,  SHIFT_SRL, 3'd0, 8'h80, 8'h01, 8'h81, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
